// File: rtl/node_reduce_tree_pkg.sv
// Shared types and constants for the node result reduction tree.
package node_reduce_tree_pkg;

  // Operation selector opcodes
  localparam int unsigned OP_UPDATE       = 0;
  localparam int unsigned OP_LOOKUP_SCAN  = 1;
  localparam int unsigned OP_LOOKUP_FINAL = 2;
  localparam int unsigned OP_ENCODE       = 3;
  localparam int unsigned OP_DELETE       = 4;
  localparam int unsigned OP_CONGRUE_UP   = 5;
  localparam int unsigned OP_CONGRUE_DOWN = 6;
  localparam int unsigned OP_MARK_AVAIL   = 7;

  // Field widths of one per-node result tuple
  localparam int unsigned RES_VALUE_W   = 8;
  localparam int unsigned RES_CONTEXT_W = 8;
  localparam int unsigned RES_IDX_W     = 3;

  // One node result travelling through the tree
  typedef struct packed {
    logic [RES_VALUE_W-1:0]   value;
    logic [RES_CONTEXT_W-1:0] ctx;
    logic                     hit;
    logic                     done;
    logic [RES_IDX_W-1:0]     index;
  } node_result_t;

endpackage

// File: rtl/node_pair_select.sv
// Combinational pair rule: merges a left (lower index) and right result.
module node_pair_select
  import node_reduce_tree_pkg::*;
#(
  parameter int unsigned SEL_W = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  node_result_t     left,
  input  node_result_t     right,
  output node_result_t     res_c
);

  logic pick_left;

  // Winner choice; contexts only matter when both sides hit, ties go right
  always_comb begin
    pick_left = 1'b0;
    if (left.hit && right.hit) begin
      if (sel == SEL_W'(OP_LOOKUP_SCAN)) begin
        pick_left = (left.ctx > right.ctx);
      end else if (sel == SEL_W'(OP_CONGRUE_UP)) begin
        pick_left = (left.ctx < right.ctx);
      end else begin
        pick_left = 1'b1;
      end
    end else begin
      pick_left = left.hit;
    end
    res_c      = pick_left ? left : right;
    res_c.hit  = left.hit | right.hit;
    res_c.done = left.done & right.done;
  end

endmodule

// File: rtl/node_reduce_tree.sv
// Pipelined reduction of NUM_NODES node results into one winner per operation.
// Optional hit counter enabled by defining NODE_REDUCE_HITCOUNT_EN.
module node_reduce_tree
  import node_reduce_tree_pkg::*;
#(
  parameter  int unsigned NUM_NODES = 8,
  parameter  int unsigned VALUE_W   = 8,
  parameter  int unsigned CONTEXT_W = 8,
  parameter  int unsigned SEL_W     = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_NODES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [SEL_W-1:0]            in_selector,
  input  logic [NUM_NODES*VALUE_W-1:0]   in_value,
  input  logic [NUM_NODES*CONTEXT_W-1:0] in_context,
  input  logic [NUM_NODES-1:0]        in_bool,
  input  logic [NUM_NODES-1:0]        in_done,
  output logic                        out_valid,
  output logic [SEL_W-1:0]            out_selector,
  output logic [VALUE_W-1:0]          out_value,
  output logic [CONTEXT_W-1:0]        out_context,
  output logic                        out_bool,
  output logic                        out_done,
  output logic [IDX_W-1:0]            out_index,
  output logic [IDX_W:0]              out_hit_count
);

  localparam int unsigned LEVELS = IDX_W;
  localparam int unsigned CNT_W  = IDX_W + 1;

  // The shared result struct fixes the field widths
  if (VALUE_W != RES_VALUE_W || CONTEXT_W != RES_CONTEXT_W || IDX_W != RES_IDX_W) begin : g_width_check
    $error("node_reduce_tree: widths must match node_reduce_tree_pkg");
  end

  // Heap layout: node 1 is the root, children of n are 2n (left) and 2n+1
  node_result_t     leaf   [NUM_NODES];
  node_result_t     node_d [1:NUM_NODES-1];
  node_result_t     node_q [1:NUM_NODES-1];
  logic [SEL_W-1:0] sel_q  [1:LEVELS];
  logic [SEL_W-1:0] sel_src[LEVELS];
  logic             valid_q[1:LEVELS];

`ifdef NODE_REDUCE_HITCOUNT_EN
  logic [CNT_W-1:0] cnt_d [1:NUM_NODES-1];
  logic [CNT_W-1:0] cnt_q [1:NUM_NODES-1];
`endif

  // Leaf tuples with their constant index
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_leaf
    assign leaf[i] = '{value: in_value[i*VALUE_W +: VALUE_W],
                       ctx:   in_context[i*CONTEXT_W +: CONTEXT_W],
                       hit:   in_bool[i],
                       done:  in_done[i],
                       index: RES_IDX_W'(i)};
  end

  // Selector feeding stage s+1 is the one carried alongside its inputs
  assign sel_src[0] = in_selector;
  for (genvar s = 1; s < LEVELS; s++) begin : g_sel_src
    assign sel_src[s] = sel_q[s];
  end

  // Combine tree: depth d of the heap is pipeline stage LEVELS-d
  for (genvar d = 0; d < LEVELS; d++) begin : g_depth
    localparam int unsigned STAGE = LEVELS - d;
    for (genvar n = (1 << d); n < (2 << d); n++) begin : g_node
      node_result_t l;
      node_result_t r;
      if (STAGE == 1) begin : g_from_leaf
        assign l = leaf[2*n - NUM_NODES];
        assign r = leaf[2*n + 1 - NUM_NODES];
`ifdef NODE_REDUCE_HITCOUNT_EN
        assign cnt_d[n] = CNT_W'(l.hit) + CNT_W'(r.hit);
`endif
      end else begin : g_from_node
        assign l = node_q[2*n];
        assign r = node_q[2*n + 1];
`ifdef NODE_REDUCE_HITCOUNT_EN
        assign cnt_d[n] = cnt_q[2*n] + cnt_q[2*n + 1];
`endif
      end
      node_pair_select #(.SEL_W(SEL_W)) u_pair (
        .sel   (sel_src[STAGE-1]),
        .left  (l),
        .right (r),
        .res_c (node_d[n])
      );
    end
  end

  // Stage data registers load every cycle; valid qualifies them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_NODES; i++) node_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_NODES; i++) node_q[i] <= node_d[i];
    end
  end

  // Valid and selector shift alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= LEVELS; s++) begin
        sel_q[s]   <= '0;
        valid_q[s] <= 1'b0;
      end
    end else begin
      sel_q[1]   <= in_selector;
      valid_q[1] <= in_valid;
      for (int s = 2; s <= LEVELS; s++) begin
        sel_q[s]   <= sel_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

`ifdef NODE_REDUCE_HITCOUNT_EN
  // Partial hit counts per tree node
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_NODES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_NODES; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign out_hit_count = cnt_q[1];
`else
  assign out_hit_count = '0;
`endif

  assign out_valid    = valid_q[LEVELS];
  assign out_selector = sel_q[LEVELS];
  assign out_value    = VALUE_W'(node_q[1].value);
  assign out_context  = CONTEXT_W'(node_q[1].ctx);
  assign out_bool     = node_q[1].hit;
  assign out_done     = node_q[1].done;
  assign out_index    = IDX_W'(node_q[1].index);

endmodule

// File: doc/node_reduce_tree.md
Name: node_reduce_tree

Overview:
- Pipelined, parametrised reduction tree. Collapses NUM_NODES per-node result tuples (value, context, bool, done) into one winning result per operation.
- Successor to the two-input node combinator. Generalised to N leaves, with registered stages, valid tracking, winner-index reporting and an optional hit count.
- Sits between the node array and the operation controller. Accepts one operation per cycle; no backpressure.

Parameters:
- NUM_NODES, 8, leaf count; power of two, >= 2.
- VALUE_W, 8, width of each node result value.
- CONTEXT_W, 8, width of each node result context.
- SEL_W, 8, operation selector width.
- Derived localparams, not overridable: IDX_W = $clog2(NUM_NODES); LEVELS = IDX_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  leaf tuple set valid this cycle.
- in_selector  in  SEL_W  opcode: 0 update, 1 lookUpScan, 2 lookUpFinalizer, 3 encode, 4 delete, 5 congrueUp, 6 congrueDown, 7 markAvailableCell.
- in_value  in  NUM_NODES*VALUE_W  node i occupies bits [i*VALUE_W +: VALUE_W].
- in_context  in  NUM_NODES*CONTEXT_W  packed the same way.
- in_bool  in  NUM_NODES  node i hit flag.
- in_done  in  NUM_NODES  node i op-done flag.
- out_valid  out  1  result valid.
- out_selector  out  SEL_W  selector carried with the result.
- out_value  out  VALUE_W  winning value.
- out_context  out  CONTEXT_W  winning context.
- out_bool  out  1  OR of all in_bool.
- out_done  out  1  AND of all in_done.
- out_index  out  IDX_W  leaf index of the winner.
- out_hit_count  out  IDX_W+1  number of set in_bool bits.

Behaviour:
- Tree has LEVELS stages, each fully registered. Level k combines adjacent pairs of level k-1 entries. Left is the lower index.
- Latency: exactly LEVELS cycles from in_valid to out_valid. Throughput is one operation per cycle. Selector and valid shift alongside the data.
- Pair rule, with L = left and R = right:
  - bool = L.bool | R.bool.
  - done = L.done & R.done.
  - Pick left when L.bool & R.bool & sel==1 & L.ctx > R.ctx (strict).
  - Pick left when L.bool & R.bool & sel==5 & L.ctx < R.ctx (strict).
  - Pick left when L.bool & R.bool & sel not in {1,5}.
  - Pick left when exactly L.bool is set.
  - In every other case pick right, including neither bool set and the equal-context ties for sel 1 and 5.
  - The chosen side supplies value, context and index.
- Leaf index i is assigned at level 0 as constant i. The index does not depend on in_valid.
- Data registers load every cycle regardless of in_valid; only the valid bit qualifies them.
- Reset: rst_n low asynchronously clears all stage registers. All outputs read 0 (out_done 0, out_index 0, out_hit_count 0, out_valid 0) until real data reaches the output stage.
- Reset deasserted mid-stream: results in flight are discarded. The first out_valid occurs LEVELS cycles after the first in_valid sampled high after reset release.
- in_valid low for a cycle produces a bubble. out_valid is low for that slot exactly.
- Back-to-back operations with different selectors never interact; each stage uses its own carried selector.
- Comparisons are unsigned, CONTEXT_W bits.
- out_hit_count: sum of in_bool, accumulated through the tree at width IDX_W+1, with no overflow possible.

Optional Feature:
- Macro NODE_REDUCE_HITCOUNT_EN.
- Defined: out_hit_count is computed and pipelined with the same latency as the other outputs.
- Undefined: no count adders or registers are built; out_hit_count is tied to 0. All other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - the selector opcode constants (OP_UPDATE=0 ... OP_MARK_AVAIL=7);
  - a result struct typedef (value, context, bool, done, index), parametrised by width localparams.
- One sub-module: node_pair_select. It is a purely combinational pair rule, instanced NUM_NODES-1 times in a generate tree. Stage registers live in the top level.

Test Plan:
1. Reset: hold rst_n=0 with random inputs, then release -> all outputs 0; out_valid stays 0 for 3 cycles (NUM_NODES=8).
2. sel=1, bool=8'b0010_0110, contexts node1=5, node2=9, node5=9 -> after 3 cycles out_bool=1, out_context=9, out_index=5 (right wins the tie), out_hit_count=3.
3. sel=5, bool=8'hFF, contexts 7,3,3,8,9,4,6,5 -> out_context=3, out_index=2 (tie goes to right), out_done = AND of done inputs.
4. sel=0, bool=8'b1001_0000 -> out_index=4 (lowest set wins); with bool=0 -> out_bool=0, out_index=7.
5. Streaming: 5 consecutive ops with sel 1,5,0,1,5 and a bubble after the 2nd -> outputs in order at 3-cycle latency, out_valid low exactly in the bubble slot.
6. Assert rst_n mid-stream with 2 ops in flight -> outputs clear immediately and neither op emerges; rebuild with NODE_REDUCE_HITCOUNT_EN undefined -> out_hit_count constant 0.
